// File: rtl/ex_divider.sv
// rtl/ex_divider.sv - iterative radix-2 restoring divider for the EX stage, signed/unsigned 32-bit.
// Optional DIV_ZERO_FLAG_EN: adds div_zero port and single-cycle divide-by-zero completion.
module ex_divider #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  annul,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic                  div_zero
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_quo;
  logic [DATA_WIDTH-1:0] r_dvs;
  logic [DATA_WIDTH-1:0] r_dividend;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic                  r_dz;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_quotient;
  logic [DATA_WIDTH-1:0] r_remainder;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_dvd_neg;
  logic                  w_dvs_neg;
  logic                  w_dvs_zero;
  logic [DATA_WIDTH-1:0] w_dvd_mag;
  logic [DATA_WIDTH-1:0] w_dvs_mag;
  logic [DATA_WIDTH:0]   w_shift;
  logic [DATA_WIDTH:0]   w_diff;
  logic                  w_diff_neg;
  logic [DATA_WIDTH-1:0] w_q_fix;
  logic [DATA_WIDTH-1:0] w_r_fix;

  assign w_accept   = (r_state == S_IDLE) && start && !annul;
  assign w_last     = (r_cnt == CNT_WIDTH'(DATA_WIDTH - 1));
  assign w_dvd_neg  = is_signed & dividend[DATA_WIDTH-1];
  assign w_dvs_neg  = is_signed & divisor[DATA_WIDTH-1];
  assign w_dvs_zero = (divisor == '0);
  assign w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_mag  = w_dvs_neg ? -divisor : divisor;

  // One restoring step: a borrow out of the top bit means the trial subtraction failed.
  assign w_shift    = {r_rem, r_quo[DATA_WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_dvs};
  assign w_diff_neg = w_diff[DATA_WIDTH];

  // Divide by zero bypasses the sign fix so both signednesses report all-ones / raw dividend.
  assign w_q_fix = r_dz ? '1 : (r_neg_q ? -r_quo : r_quo);
  assign w_r_fix = r_dz ? r_dividend : (r_neg_r ? -r_rem : r_rem);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef DIV_ZERO_FLAG_EN
          w_next = w_dvs_zero ? S_FIX : S_RUN;
`else
          w_next = S_RUN;
`endif
        end
      end
      S_RUN: begin
        if (annul)       w_next = S_IDLE;
        else if (w_last) w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_dividend  <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dz        <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rem      <= '0;
            r_quo      <= w_dvd_mag;
            r_dvs      <= w_dvs_mag;
            r_dividend <= dividend;
            r_cnt      <= '0;
            r_neg_q    <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r    <= w_dvd_neg;
            r_dz       <= w_dvs_zero;
          end
        end
        S_RUN: begin
          if (!annul) begin
            r_rem <= w_diff_neg ? w_shift[DATA_WIDTH-1:0] : w_diff[DATA_WIDTH-1:0];
            r_quo <= {r_quo[DATA_WIDTH-2:0], ~w_diff_neg};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          if (!annul) begin
            r_quotient  <= w_q_fix;
            r_remainder <= w_r_fix;
            r_done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  logic r_div_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_div_zero <= 1'b0;
    else if (w_accept)                        r_div_zero <= 1'b0;
    else if ((r_state == S_FIX) && !annul)    r_div_zero <= r_dz;
  end

  assign div_zero = r_div_zero;
`endif

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

endmodule

// File: doc/ex_divider.md
Name: ex_divider

Overview:
- Iterative radix-2 restoring divider in the EX stage.
- Computes quotient and remainder for signed and unsigned 32-bit divide instructions.
- Quotient feeds the EX result-select mux as its divider input. Quotient and remainder together feed the HI/LO write path.
- Asserts busy so the pipeline controller can stall EX while an operation is in flight.

Parameters:
- DATA_WIDTH, 32: operand/result width. Must equal the data-bus width.
- CNT_WIDTH, 6: iteration-counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a divide; sampled only in IDLE.
- is_signed  input  1  1 = signed divide, 0 = unsigned; sampled with start.
- dividend  input  DATA_WIDTH  numerator; sampled with start.
- divisor  input  DATA_WIDTH  denominator; sampled with start.
- annul  input  1  pipeline flush; abort the in-flight operation.
- busy  output  1  operation in progress; EX stall request.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  DATA_WIDTH  registered quotient; routed to the result mux.
- remainder  output  DATA_WIDTH  registered remainder; routed to HI.
- div_zero  output  1  present only with DIV_ZERO_FLAG_EN.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_zero=0; counter=0.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 and annul=0 at edge N: latch sign info and absolute values of the operands (absolute only when is_signed=1); clear partial remainder; counter=0; go to RUN; busy=1 from edge N.
  - start=0, or annul=1: stay in IDLE.
- RUN:
  - Each edge performs one iteration: shift {rem,quo} left 1; subtract divisor from the upper part; if non-negative, keep the difference and set quo[0]=1.
  - counter increments each iteration. After DATA_WIDTH iterations (edge N+32) go to FIX.
- FIX (edge N+33):
  - quotient negated if is_signed and sign(dividend)≠sign(divisor).
  - remainder negated if is_signed and dividend negative (remainder takes dividend's sign).
  - Register both outputs; done=1 for exactly one cycle; busy=0; go to IDLE.
- Latency: start sampled at edge N → done high in the cycle following edge N+33. Back-to-back start allowed in the cycle done is high, since state is already IDLE.
- Outputs hold their last values until the next FIX or reset. They do not change during RUN.
- Divide by zero (no macro): runs the full 33-cycle sequence; result quotient=all-ones, remainder=dividend (raw input), for both signed and unsigned.
- Signed overflow, 0x80000000 / 0xFFFFFFFF signed: quotient=0x80000000, remainder=0. This falls out of unsigned magnitude arithmetic plus sign fix; no special case needed.
- Annul:
  - In RUN or FIX: next edge forces IDLE; busy=0; done stays 0; quotient/remainder unchanged.
  - annul beats start in the same cycle.
- start while busy is ignored (no restart, no queueing).
- Operand inputs may change after the start cycle without effect.

Optional Feature:
- DIV_ZERO_FLAG_EN defined:
  - div_zero port exists.
  - Divisor==0 at start goes from IDLE directly to FIX. At edge N+1: quotient=all-ones, remainder=dividend, div_zero=1, done=1 (latency 1).
  - div_zero clears on the next accepted start or reset.
  - annul in that cycle behaves as above.
- Not defined:
  - No div_zero port.
  - Divide by zero takes the full 33-cycle path with the same result values.

Test Plan:
- Unsigned 100/7, start at edge 0 → busy high edges 0–32; done pulse after edge 33; quotient=14, remainder=2.
- Signed 0xFFFFFFF9 (−7) / 2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Unsigned same operands → quotient=0x7FFFFFFC, remainder=1.
- Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0, done at edge 33.
- 5/0 → quotient=0xFFFFFFFF, remainder=5. With DIV_ZERO_FLAG_EN: done and div_zero after edge 1. Without: done after edge 33.
- Start 1000/3; annul at edge 10 → busy=0 after edge 11; no done; outputs keep previous values. New start 9/4 at edge 12 → quotient=2, remainder=1 after edge 45.
- Start 50/5; assert rst asynchronously mid-RUN → busy, done, quotient, remainder all 0 immediately. Release rst, start 50/5 → quotient=10, remainder=0 with normal latency.
